mult_control: RTL

MULT_CONTROL -- requirements
Module: mult_control

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_control.sv | 72 +++++++
 2 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the 4-bit shift-add multiplier controller.
package mult_pkg;

    localparam int N_BITS  = 4;
    localparam int COUNT_W = 3;

    localparam logic [COUNT_W-1:0] CNT_EMPTY = '0;
    localparam logic [COUNT_W-1:0] CNT_LAST  = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] CNT_START = COUNT_W'(N_BITS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        TEST    = 3'd2,
        ADDST   = 3'd3,
        SHIFTST = 3'd4,
        DONE    = 3'd5
    } state_t;

endpackage : mult_pkg

// File: rtl/mult_control.sv
// Sequencer for a 4-bit shift-add multiplier; the iteration counter is a peer
// block driven through RESET/DECREMENT and read back on count.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | READY high, waiting for START
// INIT    | load operands, clear accumulator, load counter to N_BITS
// TEST    | inspect multiplier LSB (Q0) to pick add or shift
// ADDST   | add multiplicand into accumulator high half
// SHIFTST | shift accumulator/multiplier right, decrement counter
// DONE    | one-cycle VALID pulse, product available
module mult_control
    import mult_pkg::*;
(
    input  logic               clk,
    input  logic               n_reset,
    input  logic               START,
    input  logic               ABORT,
    input  logic               Q0,
    input  logic [COUNT_W-1:0] count,
    output logic               LOAD,
    output logic               RESET,
    output logic               DECREMENT,
    output logic               ADD,
    output logic               SHIFT,
    output logic               READY,
    output logic               VALID
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ABORT && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (START) state_d = INIT;
                INIT:    state_d = TEST;
                // count is never 0 here in normal operation; bail out rather than loop
                TEST: begin
                    if (count == CNT_EMPTY) state_d = DONE;
                    else if (Q0)            state_d = ADDST;
                    else                    state_d = SHIFTST;
                end
                ADDST:   state_d = SHIFTST;
                // count is sampled before this cycle's decrement takes effect
                SHIFTST: state_d = (count == CNT_LAST) ? DONE : TEST;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign READY     = (state_q == IDLE);
    assign LOAD      = (state_q == INIT);
    assign RESET     = (state_q == INIT);
    assign ADD       = (state_q == ADDST);
    assign SHIFT     = (state_q == SHIFTST);
    assign DECREMENT = (state_q == SHIFTST);
    assign VALID     = (state_q == DONE);

endmodule : mult_control
